// File: rtl/simmem_bank_sched.sv
// Single-bank DRAM timing scheduler: arbitrates one write and one read requester over an open-row model.
// Latency from acceptance to completion: hit RowHitCost, closed +ActivationCost, miss +PrechargeCost+ActivationCost.
// Accepts only in IDLE (one burst in flight); completion is held registered until done_ready_i.
module simmem_bank_sched #(
    parameter int AddrW          = 19,
    parameter int RowBufLenW     = 10,
    parameter int RowIdWidth     = AddrW - RowBufLenW,
    parameter int RowHitCost     = 4,
    parameter int PrechargeCost  = 2,
    parameter int ActivationCost = 1,
    parameter int WIidW          = 3,
    parameter int RIidW          = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [AddrW-1:0]      w_addr_i,
    input  logic [WIidW-1:0]      w_iid_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [AddrW-1:0]      r_addr_i,
    input  logic [RIidW-1:0]      r_iid_i,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic                  done_type_o,
    output logic [WIidW-1:0]      done_w_iid_o,
    output logic [RIidW-1:0]      done_r_iid_o,
    output logic                  done_row_hit_o,
    output logic                  row_open_o,
    output logic [RowIdWidth-1:0] open_row_o
);

    localparam int CntW = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        ACTIVATE,
        ACCESS,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  rr_q;        // 0: favour write, 1: favour read
    logic                  cur_type_q;
    logic [WIidW-1:0]      cur_w_iid_q;
    logic [RIidW-1:0]      cur_r_iid_q;
    logic [RowIdWidth-1:0] cur_row_q;
    logic                  cur_hit_q;

    logic [RowIdWidth-1:0] w_row, r_row, sel_row;
    logic                  w_hit, r_hit, sel_hit;
    logic                  grant_w, grant_r, accept;
    logic                  unused_addr_lsbs;

    assign w_row = w_addr_i[AddrW-1:RowBufLenW];
    assign r_row = r_addr_i[AddrW-1:RowBufLenW];
    assign w_hit = row_open_o && (w_row == open_row_o);
    assign r_hit = row_open_o && (r_row == open_row_o);
    assign unused_addr_lsbs = ^{w_addr_i[RowBufLenW-1:0], r_addr_i[RowBufLenW-1:0]};

    // A row hit beats the round-robin pointer only when it breaks a tie.
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (rst_ni && state_q == IDLE) begin
            if (w_valid_i && r_valid_i) begin
                if (w_hit && !r_hit)      grant_w = 1'b1;
                else if (r_hit && !w_hit) grant_r = 1'b1;
                else if (!rr_q)           grant_w = 1'b1;
                else                      grant_r = 1'b1;
            end else if (w_valid_i) begin
                grant_w = 1'b1;
            end else if (r_valid_i) begin
                grant_r = 1'b1;
            end
        end
    end

    assign w_ready_o = grant_w;
    assign r_ready_o = grant_r;
    assign accept    = grant_w | grant_r;
    assign sel_row   = grant_w ? w_row : r_row;
    assign sel_hit   = grant_w ? w_hit : r_hit;

    // ACCESS lasts RowHitCost-1 cycles; the DONE cycle supplies the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_hit) begin
                        state_d = ACCESS;
                        cnt_d   = CntW'(RowHitCost - 2);
                    end else if (row_open_o) begin
                        state_d = PRECHARGE;
                        cnt_d   = CntW'(PrechargeCost - 1);
                    end else begin
                        state_d = ACTIVATE;
                        cnt_d   = CntW'(ActivationCost - 1);
                    end
                end
            end
            PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = ACTIVATE;
                    cnt_d   = CntW'(ActivationCost - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACTIVATE: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                    cnt_d   = CntW'(RowHitCost - 2);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                if (done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rr_q           <= 1'b0;
            cur_type_q     <= 1'b0;
            cur_w_iid_q    <= '0;
            cur_r_iid_q    <= '0;
            cur_row_q      <= '0;
            cur_hit_q      <= 1'b0;
            row_open_o     <= 1'b0;
            open_row_o     <= '0;
            done_valid_o   <= 1'b0;
            done_type_o    <= 1'b0;
            done_w_iid_o   <= '0;
            done_r_iid_o   <= '0;
            done_row_hit_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cur_type_q  <= grant_r;
                cur_w_iid_q <= grant_w ? w_iid_i : '0;
                cur_r_iid_q <= grant_r ? r_iid_i : '0;
                cur_row_q   <= sel_row;
                cur_hit_q   <= sel_hit;
                if (w_valid_i && r_valid_i) rr_q <= grant_w;
            end
            // A hit re-enters ACCESS on the already open row, so only ACTIVATE updates it.
            if (state_q == ACTIVATE && state_d == ACCESS) begin
                row_open_o <= 1'b1;
                open_row_o <= cur_row_q;
            end
            if (state_q == ACCESS && state_d == DONE) begin
                done_valid_o   <= 1'b1;
                done_type_o    <= cur_type_q;
                done_w_iid_o   <= cur_w_iid_q;
                done_r_iid_o   <= cur_r_iid_q;
                done_row_hit_o <= cur_hit_q;
            end else if (state_q == DONE && done_ready_i) begin
                done_valid_o   <= 1'b0;
                done_type_o    <= 1'b0;
                done_w_iid_o   <= '0;
                done_r_iid_o   <= '0;
                done_row_hit_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/simmem_bank_sched.md
Name: simmem_bank_sched

Overview:
Single-bank DRAM timing scheduler for the simulated memory controller. It arbitrates between one write-address requester and one read-address requester, tracking the open row buffer. It sequences each accepted burst through precharge, activation and access phases using the system cost constants. It emits one completion token per burst, tagged with the burst's internal identifier, to the response-bank release logic.

Parameters:
AddrW, 19, address width (GlobalMemCapaW)
RowBufLenW, 10, log2 of row buffer length in bytes
RowIdWidth, AddrW-RowBufLenW, row identifier width
RowHitCost, 4, access cycles; must be >=3
PrechargeCost, 2, precharge cycles; must be >=1
ActivationCost, 1, activation cycles; must be >=1
WIidW, 3, write internal id width (WRspBankAddrW)
RIidW, 2, read internal id width (RDataBankAddrW)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
w_valid_i  in  1  write request valid
w_ready_o  out  1  write request accepted
w_addr_i  in  AddrW  write burst start address
w_iid_i  in  WIidW  write internal id
r_valid_i  in  1  read request valid
r_ready_o  out  1  read request accepted
r_addr_i  in  AddrW  read burst start address
r_iid_i  in  RIidW  read internal id
done_valid_o  out  1  completion valid
done_ready_i  in  1  completion consumed
done_type_o  out  1  rsp_bank_type_e: 0 WRSP_BANK, 1 RDATA_BANK
done_w_iid_o  out  WIidW  write iid; 0 when done_type_o=1
done_r_iid_o  out  RIidW  read iid; 0 when done_type_o=0
done_row_hit_o  out  1  completed burst was a row hit
row_open_o  out  1  a row is open
open_row_o  out  RowIdWidth  open row id; 0 when closed

Behaviour:
- Clock is clk_i. Reset rst_ni is synchronous and active-low.
- Row id of a request = addr[AddrW-1:RowBufLenW].
- FSM states: IDLE, PRECHARGE, ACTIVATE, ACCESS, DONE. Reset state is IDLE.
- Reset values: done_valid_o=0, all done_* fields=0, row_open_o=0, open_row_o=0, RR pointer favours write.
- Any cycle with rst_ni=0 forces w_ready_o=r_ready_o=0. A reset mid-operation drops the in-flight burst with no completion and closes the row.
- IDLE arbitration (combinational; at most one ready high, only in IDLE):
  - Only one valid: grant it.
  - Both valid, exactly one is a row hit (row_open_o=1 and rows match): grant the hit.
  - Otherwise grant per RR pointer. The pointer flips to the other requester after any grant made while both were valid.
- Acceptance handshake occurs in cycle T. The request classifies as:
  - hit: row open and equal
  - closed: no row open
  - miss: row open and different
- Phase sequence after T:
  - miss: PRECHARGE for PrechargeCost cycles, then ACTIVATE for ActivationCost cycles
  - closed: ACTIVATE for ActivationCost cycles
  - all: ACCESS for RowHitCost-1 cycles, then DONE
- A single down-counter is reloaded with cost-1 on each phase entry. A phase exits when the counter is 0.
- Latency L is from T to the first cycle done_valid_o=1:
  - hit: L=RowHitCost (4)
  - closed: L=ActivationCost+RowHitCost (5)
  - miss: L=PrechargeCost+ActivationCost+RowHitCost (7)
- row_open_o/open_row_o update on entry to ACCESS, and hold until the next ACTIVATE completes or reset.
- DONE: done_valid_o and all done_* fields are registered and stable until done_ready_i=1. On handshake, return to IDLE. No request is accepted in the handshake cycle. Minimum request spacing is L+1 cycles.
- done_row_hit_o=1 only for hit class.
- Requests arriving outside IDLE stall with ready=0. Per AXI, valid is not withdrawn; the block does not check this.

Test Plan:
- After reset, w_valid_i=1, w_addr_i=0x00400, w_iid_i=5 at T -> closed access. done_valid_o=1 at T+5 with done_type_o=0, done_w_iid_o=5, done_row_hit_o=0. row_open_o=1, open_row_o=1 from T+2.
- Then r_addr_i=0x007FC, r_iid_i=2 (row 1) -> hit. done at T'+4 with done_type_o=1, done_r_iid_o=2, done_row_hit_o=1.
- Then r_addr_i=0x00800 (row 2) -> miss. done at T'+7 with done_row_hit_o=0 and open_row_o=2.
- Open row 2; in IDLE, w_addr_i=0x00C00 (row 3) and r_addr_i=0x00A00 (row 2) both valid -> r_ready_o=1, w_ready_o=0. The write is served next as a miss.
- Row closed; both valid on distinct rows for 4 consecutive grants -> order W,R,W,R. Pointer alternates each grant.
- Hold done_ready_i=0 for 10 cycles -> done_valid_o and fields stable, both ready=0. Then rst_ni=0 for 1 cycle mid-ACCESS of a later burst -> no completion, row_open_o=0, and the next request is classified closed.
